// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and elaboration helpers for the synchronous FIFO family
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int depth, input int af, input int ae);
        return depth >= 2 && (depth & (depth - 1)) == 0 &&
               af >= 1 && af <= depth && ae >= 0 && ae < depth;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register-array storage with one synchronous write port and one asynchronous read port
module fifo_mem import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = clog2(DEF_FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with occupancy count, programmable flags, error pulses, flush and FWFT mode
module fifo_sync_flags import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_empty,
    output logic                        almost_full,
    output logic [clog2(FIFO_DEPTH):0]  count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = FIFO_DEPTH[CW-1:0];
    localparam logic [CW-1:0] AF_C    = AF_THRESH[CW-1:0];
    localparam logic [CW-1:0] AE_C    = AE_THRESH[CW-1:0];

    if (!params_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("fifo_sync_flags: FIFO_DEPTH must be a power of 2 >= 2 and thresholds in range");
    end

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_acc, wr_acc;

    assign empty        = count == '0;
    assign full         = count == DEPTH_C;
    assign almost_empty = count <= AE_C;
    assign almost_full  = count >= AF_C;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge
    assign rd_acc = cs & rd_en & ~empty;
    assign wr_acc = cs & wr_en & (~full | rd_acc);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc & ~clr),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(wr_acc);
            rd_ptr    <= rd_ptr + AW'(rd_acc);
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
            overflow  <= cs & wr_en & ~wr_acc;
            underflow <= cs & rd_en & ~rd_acc;
        end

    if (FWFT) begin : g_fwft
        assign data_out = rd_data;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)      dout_q <= '0;
            else if (clr)    dout_q <= '0;
            else if (rd_acc) dout_q <= rd_data;
        assign data_out = dout_q;
    end

endmodule
